multicycle_control: RTL

Parametrised multi-cycle successor to the single-cycle combinational control unit. Sequences each instruction through FETCH, DECODE, EXEC and an optional MEM wait state, and handshakes with instruction memory and data RAM. Drives the ALU, register file, RAM and PC. It sits between the PC/instruction memory and the datapath, and counts retired instructions.

---
 rtl/cu_pkg.sv | 38 +++
 rtl/multicycle_control_if.sv | 36 +++
 rtl/cu_decode.sv | 36 +++
 rtl/multicycle_control.sv | 166 ++++++++++++++++
 4 files changed

// File: rtl/cu_pkg.sv
// Shared opcodes, ALU codes, FSM states and instruction classes
// for the multi-cycle control unit.
package cu_pkg;

  localparam logic [3:0] OP_ADD   = 4'b0000;
  localparam logic [3:0] OP_SUB   = 4'b0100;
  localparam logic [3:0] OP_LOAD  = 4'b1000;
  localparam logic [3:0] OP_STORE = 4'b1001;
  localparam logic [3:0] OP_JUMP  = 4'b1100;

  localparam logic [3:0] ALU_ADD = 4'b1000;
  localparam logic [3:0] ALU_SUB = 4'b0100;

  typedef enum logic [1:0] {
    FETCH  = 2'd0,
    DECODE = 2'd1,
    EXEC   = 2'd2,
    MEM    = 2'd3
  } state_e;

  typedef enum logic [2:0] {
    CL_NOP,
    CL_ALU,
    CL_LOAD,
    CL_STORE,
    CL_JUMP,
    CL_BRANCH
  } cls_e;

  // 1101, 1110 and 1111 are compare-and-branch; 1100 is JUMP
  function automatic logic is_branch(
    input logic [3:0] op
  );
    return (op[3:2] == 2'b11) &&
           (op[1:0] != 2'b00);
  endfunction

endpackage

// File: rtl/multicycle_control_if.sv
// Instruction-fetch and data-RAM handshake bundle
// between the control unit (master) and memories (slave).
interface multicycle_control_if #(
  parameter int INSTR_W = 16,
  parameter int ADDR_W  = 8
);

  logic [INSTR_W-1:0] instr;
  logic               instr_valid;
  logic               instr_req;
  logic               ram_ready;
  logic               ram_read;
  logic               ram_write;
  logic [ADDR_W-1:0]  ram_adr;

  modport master (
    input  instr,
    input  instr_valid,
    input  ram_ready,
    output instr_req,
    output ram_read,
    output ram_write,
    output ram_adr
  );

  modport slave (
    output instr,
    output instr_valid,
    output ram_ready,
    input  instr_req,
    input  ram_read,
    input  ram_write,
    input  ram_adr
  );

endinterface

// File: rtl/cu_decode.sv
// Opcode to instruction class and ALU code.
// STORE decodes only when CU_STORE_EN is defined.
module cu_decode
  import cu_pkg::*;
(
  input  logic [3:0] op_i,
  output cls_e       cls_o,
  output logic [3:0] alu_code_o
);

  always_comb begin
    cls_o      = CL_NOP;
    alu_code_o = 4'b0000;
    unique case (1'b1)
      (op_i == OP_ADD): begin
        cls_o      = CL_ALU;
        alu_code_o = ALU_ADD;
      end
      (op_i == OP_SUB): begin
        cls_o      = CL_ALU;
        alu_code_o = ALU_SUB;
      end
      (op_i == OP_LOAD): cls_o = CL_LOAD;
`ifdef CU_STORE_EN
      (op_i == OP_STORE): cls_o = CL_STORE;
`endif
      (op_i == OP_JUMP): cls_o = CL_JUMP;
      is_branch(op_i): begin
        cls_o      = CL_BRANCH;
        alu_code_o = op_i;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/multicycle_control.sv
// Multi-cycle FETCH/DECODE/EXEC/MEM control unit with retire counter.
// Define CU_STORE_EN to enable STORE (opcode 1001) and ram_write.
module multicycle_control
  import cu_pkg::*;
#(
  parameter int REG_AW = 2,
  parameter int ADDR_W = 8,
  parameter int CNT_W  = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  multicycle_control_if.master    bus_if,
  input  logic                    branch_check_i,
  output logic [3:0]              alu_code_o,
  output logic                    reg_read_o,
  output logic                    reg_write_o,
  output logic [REG_AW-1:0]       reg1_o,
  output logic [REG_AW-1:0]       reg2_o,
  output logic                    pc_inc_o,
  output logic                    pc_jump_o,
  output logic                    pc_branch_o,
  output logic                    busy_o,
  output logic [CNT_W-1:0]        retired_o
);

  localparam int INSTR_W = 4 + 2*REG_AW + ADDR_W;

  state_e             state_q, state_d;
  logic [INSTR_W-1:0] ir_q, ir_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;

  logic [3:0]        op;
  logic [ADDR_W-1:0] adr;
  cls_e              cls;
  logic [3:0]        dec_alu;

  logic              req;
  logic              ram_rd;
  logic              ram_wr;
  logic [ADDR_W-1:0] ram_adr;
  logic              retire;

  assign op  = ir_q[INSTR_W-1 -: 4];
  assign adr = ir_q[ADDR_W-1:0];

  cu_decode u_dec (
    .op_i       (op),
    .cls_o      (cls),
    .alu_code_o (dec_alu)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      ir_q    <= ir_d;
      cnt_q   <= cnt_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    ir_d        = ir_q;
    req         = 1'b0;
    ram_rd      = 1'b0;
    ram_wr      = 1'b0;
    ram_adr     = '0;
    alu_code_o  = '0;
    reg_read_o  = 1'b0;
    reg_write_o = 1'b0;
    reg1_o      = '0;
    reg2_o      = '0;
    pc_inc_o    = 1'b0;
    pc_jump_o   = 1'b0;
    pc_branch_o = 1'b0;
    busy_o      = 1'b0;
    if (state_q != FETCH) begin
      reg1_o  = ir_q[ADDR_W+REG_AW +: REG_AW];
      reg2_o  = ir_q[ADDR_W +: REG_AW];
      ram_adr = adr;
      busy_o  = 1'b1;
    end
    unique case (state_q)
      FETCH: begin
        req = 1'b1;
        if (bus_if.instr_valid) begin
          ir_d    = bus_if.instr;
          state_d = DECODE;
        end
      end
      DECODE: begin
        reg_read_o = 1'b1;
        state_d    = EXEC;
      end
      EXEC: begin
        state_d = FETCH;
        unique case (cls)
          CL_ALU: begin
            alu_code_o  = dec_alu;
            reg_write_o = 1'b1;
            pc_inc_o    = 1'b1;
          end
          CL_LOAD,
          CL_STORE: state_d = MEM;
          CL_JUMP: pc_jump_o = 1'b1;
          CL_BRANCH: begin
            alu_code_o  = dec_alu;
            pc_branch_o = branch_check_i;
            pc_inc_o    = !branch_check_i;
          end
          default: pc_inc_o = 1'b1;
        endcase
      end
      MEM: begin
        if (cls == CL_LOAD) begin
          ram_rd = 1'b1;
          if (bus_if.ram_ready) begin
            reg_write_o = 1'b1;
            pc_inc_o    = 1'b1;
            state_d     = FETCH;
          end
`ifdef CU_STORE_EN
        end else if (cls == CL_STORE) begin
          ram_wr = 1'b1;
          if (bus_if.ram_ready) begin
            pc_inc_o = 1'b1;
            state_d  = FETCH;
          end
`endif
        end else begin
          state_d = FETCH;
        end
      end
      default: state_d = FETCH;
    endcase
    // hold every output low while reset is asserted
    if (rst) begin
      req         = 1'b0;
      ram_rd      = 1'b0;
      ram_wr      = 1'b0;
      ram_adr     = '0;
      alu_code_o  = '0;
      reg_read_o  = 1'b0;
      reg_write_o = 1'b0;
      reg1_o      = '0;
      reg2_o      = '0;
      pc_inc_o    = 1'b0;
      pc_jump_o   = 1'b0;
      pc_branch_o = 1'b0;
      busy_o      = 1'b0;
    end
  end

  assign retire = pc_inc_o | pc_jump_o | pc_branch_o;
  assign cnt_d  = retire ? cnt_q + 1'b1 : cnt_q;

  assign retired_o        = rst ? '0 : cnt_q;
  assign bus_if.instr_req = req;
  assign bus_if.ram_read  = ram_rd;
  assign bus_if.ram_write = ram_wr;
  assign bus_if.ram_adr   = ram_adr;

endmodule
